// File: rtl/fanout_seq_pkg.sv
// Shared types, default parameters and width helper for fanout_group_sequencer.
package fanout_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_NUM_GROUPS  = 4;
    localparam int unsigned DEF_SETTLE_CYC  = 2;
    localparam int unsigned DEF_TIMEOUT_CYC = 15;

    // Bits needed to index n items, never less than one
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around. The priority pointer itself lives in the parent.
module rr_arbiter
    import fanout_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   win_idx
);

    // Scan from ptr with explicit modulo wrap; first hit wins
    always_comb begin
        int unsigned      j;
        logic [PTR_W-1:0] jw;
        logic             found;
        gnt     = '0;
        win_idx = '0;
        found   = 1'b0;
        j       = 0;
        jw      = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            j = 32'(ptr) + off;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jw = PTR_W'(j);
            if (en && !found && req[jw]) begin
                found   = 1'b1;
                gnt[jw] = 1'b1;
                win_idx = jw;
            end
        end
    end

endmodule

// File: rtl/fanout_group_sequencer.sv
// Arbitrates requesters for a shared broadcast net and enables its buffered
// fanout groups one at a time, each held SETTLE_CYC cycles, then pulses done.
// Optional build macro FANOUT_ACK_TIMEOUT_EN: each group additionally waits for
// sink_ack[grp], with a TIMEOUT_CYC watchdog that sets the sticky err flag.
module fanout_group_sequencer
    import fanout_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned NUM_GROUPS  = DEF_NUM_GROUPS,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      iccad_clk,
    input  logic                      iccad_rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         bcast_data,
    output logic [NUM_GROUPS-1:0]     grp_en,
    input  logic [NUM_GROUPS-1:0]     sink_ack,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned GRP_W = clog2_min1(NUM_GROUPS);
    localparam int unsigned CNT_W = clog2_min1(SETTLE_CYC);
    localparam int unsigned PTR_W = clog2_min1(NUM_REQ);

    state_e                state_q, state_d;
    logic [GRP_W-1:0]      grp_q, grp_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      win_q, win_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [NUM_GROUPS-1:0] grp_en_q, grp_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  arb_en_c;
    logic [NUM_REQ-1:0]    gnt_c;
    logic [PTR_W-1:0]      win_c;
    logic                  settle_exit_c;
    logic [DATA_W-1:0]     req_arr_c [NUM_REQ];

    // Split the flat request bus into one word per requester
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_arr_c[i] = req_data[i*DATA_W +: DATA_W];
    end

    // Accept only in IDLE; gating with reset keeps req_ready low while reset is held
    assign arb_en_c = (state_q == IDLE) && iccad_rst_n;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en_c),
        .gnt     (gnt_c),
        .win_idx (win_c)
    );

`ifdef FANOUT_ACK_TIMEOUT_EN
    localparam int unsigned TO_W = clog2_min1(TIMEOUT_CYC);

    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
    logic            ack_ok_c;
    logic            to_hit_c;

    assign ack_ok_c      = (cnt_q == '0) && sink_ack[grp_q];
    assign to_hit_c      = (to_q == TO_W'(TIMEOUT_CYC - 1));
    assign settle_exit_c = ack_ok_c || to_hit_c;

    // Ack watchdog: restarts per group, saturates, flags a forced advance
    always_comb begin
        to_d  = to_q;
        err_d = err_q;
        if (state_q == DRIVE) begin
            to_d = '0;
        end else if (state_q == SETTLE) begin
            if (!to_hit_c) begin
                to_d = to_q + TO_W'(1);
            end
            if (to_hit_c && !ack_ok_c) begin
                err_d = 1'b1;
            end
        end
    end

    // Watchdog registers
    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic [NUM_GROUPS-1:0]  sink_ack_unused;
    localparam int unsigned timeout_cyc_unused = TIMEOUT_CYC;

    assign sink_ack_unused = sink_ack;
    assign settle_exit_c   = (cnt_q == '0);
    assign err             = 1'b0;
`endif

    // Next-state and datapath; registered outputs are derived from the next state
    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        data_d   = data_q;
        grp_en_d = grp_en_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|gnt_c) begin
                    win_d   = win_c;
                    data_d  = req_arr_c[win_c];
                    grp_d   = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d   = CNT_W'(SETTLE_CYC - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_exit_c) begin
                    if (grp_q == GRP_W'(NUM_GROUPS - 1)) begin
                        state_d = DONE;
                    end else begin
                        grp_d   = grp_q + GRP_W'(1);
                        state_d = DRIVE;
                    end
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == DRIVE) begin
            grp_en_d = grp_en_q | (NUM_GROUPS'(1) << grp_d);
        end else if (state_d == IDLE) begin
            grp_en_d = '0;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // FSM state register
    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            grp_q    <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            win_q    <= '0;
            data_q   <= '0;
            grp_en_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            grp_q    <= grp_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            data_q   <= data_d;
            grp_en_q <= grp_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign req_ready  = gnt_c;
    assign bcast_data = data_q;
    assign grp_en     = grp_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_fanout_group_sequencer.sv
// Directed bench for fanout_group_sequencer: default instance plus a
// NUM_GROUPS=1 / SETTLE_CYC=1 instance for the short-sequence boundary.
module tb_fanout_group_sequencer;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_GROUPS = 4;

    logic                      iccad_clk = 1'b0;
    logic                      iccad_rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         bcast_data;
    logic [NUM_GROUPS-1:0]     grp_en;
    logic [NUM_GROUPS-1:0]     sink_ack;
    logic                      busy, done, err;

    logic [NUM_REQ-1:0]        b_req_valid;
    logic [NUM_REQ*DATA_W-1:0] b_req_data;
    logic [NUM_REQ-1:0]        b_req_ready;
    logic [DATA_W-1:0]         b_bcast_data;
    logic [0:0]                b_grp_en;
    logic [0:0]                b_sink_ack;
    logic                      b_busy, b_done, b_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fanout_group_sequencer #(
        .NUM_REQ(4), .DATA_W(8), .NUM_GROUPS(4), .SETTLE_CYC(2), .TIMEOUT_CYC(15)
    ) dut (
        .iccad_clk  (iccad_clk),
        .iccad_rst_n(iccad_rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .bcast_data (bcast_data),
        .grp_en     (grp_en),
        .sink_ack   (sink_ack),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    fanout_group_sequencer #(
        .NUM_REQ(4), .DATA_W(8), .NUM_GROUPS(1), .SETTLE_CYC(1), .TIMEOUT_CYC(15)
    ) dut_b (
        .iccad_clk  (iccad_clk),
        .iccad_rst_n(iccad_rst_n),
        .req_valid  (b_req_valid),
        .req_data   (b_req_data),
        .req_ready  (b_req_ready),
        .bcast_data (b_bcast_data),
        .grp_en     (b_grp_en),
        .sink_ack   (b_sink_ack),
        .busy       (b_busy),
        .done       (b_done),
        .err        (b_err)
    );

    always #5 iccad_clk = ~iccad_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge iccad_clk);
        #1;
    endtask

    // Requester protocol: a pending request may only drop after its accept pulse
    logic [NUM_REQ-1:0] pend_q;
    always @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                assert (!(pend_q[i] && !req_valid[i]))
                    else $error("FAIL proto: requester %0d dropped req_valid early", i);
            end
            pend_q <= req_valid & ~req_ready;
        end
    end

    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    int ng;
    int last;

    initial begin
        iccad_rst_n = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        sink_ack    = '1;
        b_req_valid = '0;
        b_req_data  = '0;
        b_sink_ack  = 1'b1;
        repeat (2) tick();

        // Reset values
        check("rst_ready", req_ready, 0);
        check("rst_bcast", bcast_data, 0);
        check("rst_grp_en", grp_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        iccad_rst_n = 1'b1;
        tick();

        // Single request from requester 0
        req_data  = 32'h0000_00A5;
        req_valid = 4'b0001;
        #1;
        check("t1_accept_ready", req_ready, 4'b0001);
        check("t1_accept_busy", busy, 0);
        tick();
        req_valid = '0;
        for (int k = 1; k <= 14; k++) begin
            int         cnt;
            logic [3:0] m;
            #1;
            cnt = (k - 1) / 3 + 1;
            if (cnt > 4) cnt = 4;
            m = (k <= 13) ? 4'((1 << cnt) - 1) : 4'b0000;
            check("t1_grp_en", grp_en, m);
            check("t1_done", done, k == 13);
            check("t1_busy", busy, k <= 13);
            if (k == 1 || k == 13) check("t1_bcast", bcast_data, 8'hA5);
            if (k == 13) begin
                req_valid = 4'b0010;
                req_data  = 32'h0000_5A00;
                #1;
                check("t1_no_accept_in_done", req_ready, 0);
            end
            if (k == 14) check("t1_accept_after_done", req_ready, 4'b0010);
            if (k < 14) tick();
        end
        tick();
        req_valid = '0;
        repeat (12) tick();
        #1;
        check("t1b_done", done, 1);
        check("t1b_bcast", bcast_data, 8'h5A);
        tick();
        check("t1b_idle_busy", busy, 0);
        check("t1b_idle_grp_en", grp_en, 0);
        check("t1b_bcast_hold", bcast_data, 8'h5A);
        check("t1b_err", err, 0);

        iccad_rst_n = 1'b0;
        tick();
        iccad_rst_n = 1'b1;
        tick();

        // All four requesting continuously
        req_data  = 32'h4433_2211;
        req_valid = 4'hF;
        ng   = 0;
        last = 0;
        for (int c = 0; c < 120 && ng < 6; c++) begin
            #1;
            if (ng > 0 && c == last + 1)
                check("t2_bcast", bcast_data, 32'((exp_order[ng-1] + 1) * 17));
            if (req_ready != '0) begin
                check("t2_order", req_ready, 32'(1 << exp_order[ng]));
                if (ng > 0) check("t2_gap", 32'(c - last), 14);
                last = c;
                ng++;
            end
            check("t2_busy", busy, req_ready == '0);
            if (ng < 6) tick();
        end
        if (ng < 6) check("t2_grant_timeout", ng, 6);

        // Reset during SETTLE of group 2 of the transaction just accepted
        repeat (8) tick();
        #1;
        check("t3_pre_grp_en", grp_en, 4'b0111);
        iccad_rst_n = 1'b0;
        #1;
        check("t3_ready", req_ready, 0);
        check("t3_bcast", bcast_data, 0);
        check("t3_grp_en", grp_en, 0);
        check("t3_busy", busy, 0);
        check("t3_done", done, 0);
        check("t3_err", err, 0);
        tick();
        iccad_rst_n = 1'b1;
        #1;
        check("t3_first_grant", req_ready, 4'b0001);
        iccad_rst_n = 1'b0;
        req_valid   = '0;
        tick();
        iccad_rst_n = 1'b1;
        tick();

        // One group, one settle cycle
        b_req_data  = 32'h003C_0000;
        b_req_valid = 4'b0100;
        #1;
        check("t4_accept", b_req_ready, 4'b0100);
        tick();
        b_req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check("t4_done", b_done, k == 3);
            check("t4_grp_en", b_grp_en, k <= 3);
            check("t4_busy", b_busy, k <= 3);
            if (k == 3) check("t4_bcast", b_bcast_data, 8'h3C);
            if (k < 4) tick();
        end
        check("t4_err", b_err, 0);

`ifdef FANOUT_ACK_TIMEOUT_EN
        // Group 1 never acknowledges: watchdog forces it through
        tick();
        sink_ack  = 4'b1101;
        req_data  = 32'h0000_0077;
        req_valid = 4'b0001;
        #1;
        check("t5_accept", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        for (int k = 1; k <= 26; k++) begin
            #1;
            if (k == 19) begin
                check("t5_grp_en_hold", grp_en, 4'b0011);
                check("t5_err_before", err, 0);
            end
            if (k == 20) begin
                check("t5_grp_en_next", grp_en, 4'b0111);
                check("t5_err_set", err, 1);
            end
            check("t5_done", done, k == 26);
            if (k < 26) tick();
        end
        sink_ack = '1;
        tick();
        tick();
        check("t5_err_sticky", err, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
